mem_arbiter: RTL and testbench

//  Shares the single-port program/data memory between two requesters: port 0 (CPU) and port 1 (debug/loader).

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_if.sv | 19 +
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option MEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Wide enough for any MAX_WAIT in 1..15.
    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side bundle of the arbiter: req/gnt handshake, access fields and completion.
// master = requester, slave = arbiter.
interface mem_arb_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, done, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, done, rdata);

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two requesters.
// MEM_ARB_RR_EN: round robin on last_winner; otherwise fixed priority with starvation guard.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              req0,
    input  logic              req1,
    input  logic              last_winner,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic              winner,
    output logic              valid
);

`ifdef MEM_ARB_RR_EN
    logic [WAIT_W-1:0] unused_wait_cnt;
    assign unused_wait_cnt = wait_cnt;

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_winner;
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner;

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        // Port 1 wins alone, or when it has been passed over MAX_WAIT times in a row.
        if (req1 && (!req0 || wait_cnt == WAIT_W'(MAX_WAIT))) begin
            winner = PORT_DBG;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between CPU (port 0) and debug/loader (port 1).
// Each access runs IDLE(gnt) -> ACCESS -> RESP(done); MEM_ARB_RR_EN selects round robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_arb_if.slave              r0,
    mem_arb_if.slave              r1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  owner,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  we_q, id_q, last_winner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata0_q, rdata1_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  win, win_valid, cap;
    logic                  gnt0, gnt1, done0, done1;

    mem_arb_pick #(
        .MAX_WAIT(MAX_WAIT)
    ) u_pick (
        .req0       (r0.req),
        .req1       (r1.req),
        .last_winner(last_winner_q),
        .wait_cnt   (wait_cnt),
        .winner     (win),
        .valid      (win_valid)
    );

    assign cap = (state_q == StIdle) && win_valid && !rst;

    always_comb begin
        state_d  = state_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        case (state_q)
            StIdle: begin
                if (cap) begin
                    state_d = StAccess;
                    gnt0    = (win == PORT_CPU);
                    gnt1    = (win == PORT_DBG);
                end
            end
            StAccess: begin
                mem_addr = addr_q;
                mem_data = wdata_q;
                // A reset landing here must not let the write through.
                mem_we   = we_q && !rst;
                state_d  = StResp;
            end
            StResp: begin
                done0   = !rst && (id_q == PORT_CPU);
                done1   = !rst && (id_q == PORT_DBG);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            id_q          <= PORT_CPU;
            last_winner_q <= PORT_DBG;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                we_q          <= win ? r1.we : r0.we;
                addr_q        <= win ? r1.addr : r0.addr;
                wdata_q       <= win ? r1.wdata : r0.wdata;
                id_q          <= win;
                last_winner_q <= win;
            end
            if (done0 && !we_q) rdata0_q <= mem_out;
            if (done1 && !we_q) rdata1_q <= mem_out;
        end
    end

`ifdef MEM_ARB_RR_EN
    assign wait_cnt = '0;
`else
    logic [WAIT_W-1:0] wait_cnt_q;
    assign wait_cnt = wait_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !r1.req) begin
            wait_cnt_q <= '0;
        end else if (cap) begin
            if (win == PORT_DBG) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
        end
    end
`endif

    // Read data is forwarded straight from memory during the done cycle.
    assign r0.gnt   = gnt0;
    assign r1.gnt   = gnt1;
    assign r0.done  = done0;
    assign r1.done  = done1;
    assign r0.rdata = (done0 && !we_q) ? mem_out : rdata0_q;
    assign r1.rdata = (done1 && !we_q) ? mem_out : rdata1_q;
    assign owner    = id_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a registered-read memory model.
// Define MEM_ARB_RR_EN to check the round-robin build instead of fixed priority.
module tb_mem_arbiter;

    typedef struct {
        bit          port;
        bit          rd;
        logic [15:0] data;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we, owner, busy;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] mem_out = '0;
    logic [15:0] mem [64];

    int n_cmp = 0, n_bad = 0, n_we = 0;
    int cyc = 0, gnt_cyc = 0, we_cyc = 0, done_cyc = 0;
    logic [5:0] we_addr = '0;

    bit    exp_gnt[$];
    done_t exp_done[$];

    mem_arb_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) p0 ();
    mem_arb_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) p1 ();

    mem_arbiter #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(16),
        .MAX_WAIT  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .r0      (p0.slave),
        .r1      (p1.slave),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_out (mem_out),
        .owner   (owner),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT grants or completes.
    always @(negedge clk) begin
        if (mem_we) begin
            n_we++;
            we_cyc  = cyc;
            we_addr = mem_addr;
        end
        if (p0.gnt || p1.gnt || p0.done || p1.done)
            check("one_event_per_cycle", 32'(p0.gnt) + 32'(p1.gnt) + 32'(p0.done) + 32'(p1.done), 1);
        if (p0.gnt || p1.gnt) begin
            gnt_cyc = cyc;
            if (exp_gnt.size() == 0) fail("unexpected_gnt");
            else check("gnt_port", 32'(p1.gnt), 32'(exp_gnt.pop_front()));
        end
        if (p0.done || p1.done) begin
            done_cyc = cyc;
            if (exp_done.size() == 0) fail("unexpected_done");
            else begin
                done_t e;
                e = exp_done.pop_front();
                check("done_port", 32'(p1.done), 32'(e.port));
                if (e.rd) check("rdata", 32'(e.port ? p1.rdata : p0.rdata), 32'(e.data));
            end
        end
    end

    task automatic drive(input bit port, input bit req, input bit we, input logic [5:0] addr,
                         input logic [15:0] wdata);
        if (port) begin
            p1.req = req; p1.we = we; p1.addr = addr; p1.wdata = wdata;
        end else begin
            p0.req = req; p0.we = we; p0.addr = addr; p0.wdata = wdata;
        end
    endtask

    task automatic wait_gnt(input bit port);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = port ? p1.gnt : p0.gnt;
        end
        if (!seen) $display("FAIL gnt_timeout: port %0d got no gnt expected gnt", port);
        if (!seen) n_bad++;
        n_cmp++;
    endtask

    task automatic request(input bit port, input bit we, input logic [5:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rd_exp);
        exp_gnt.push_back(port);
        exp_done.push_back('{port, !we, rd_exp});
        drive(port, 1'b1, we, addr, wdata);
        wait_gnt(port);
        @(posedge clk); #1;
        drive(port, 1'b0, we, addr, wdata);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((exp_gnt.size() != 0 || exp_done.size() != 0) && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("drain_gnt_q", exp_gnt.size(), 0);
        check("drain_done_q", exp_done.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Hold the enabled requests until n grants; continuous requests must be spaced 3 cycles.
    task automatic burst(input bit on0, input bit on1, input int n);
        int cnt = 0, last = 0;
        p0.req = on0;
        p1.req = on1;
        for (int i = 0; i < n * 3 + 20 && cnt < n; i++) begin
            @(negedge clk);
            if (p0.gnt || p1.gnt) begin
                if (cnt > 0) check("gnt_spacing", cyc - last, 3);
                last = cyc;
                cnt++;
            end
        end
        check("burst_gnt_count", cnt, n);
        @(posedge clk); #1;
        p0.req = 1'b0;
        p1.req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {p0.gnt, p1.gnt, p0.done, p1.done}, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int we0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        do_reset();
        check("rst_rdata", {p0.rdata, p1.rdata}, 0);

        // 1: write then read back, with cycle-exact write/done placement
        we0 = n_we;
        request(0, 1, 6'd5, 16'hBEEF, '0);
        wait_idle();
        check("t1_we_count", n_we - we0, 1);
        check("t1_we_cyc", we_cyc, gnt_cyc + 1);
        check("t1_done_cyc", done_cyc, gnt_cyc + 2);
        request(0, 0, 6'd5, '0, 16'hBEEF);
        wait_idle();

`ifdef MEM_ARB_RR_EN
        // 3: round robin from reset (last winner = port 1)
        do_reset();
        foreach (exp_gnt[i]) exp_gnt.delete(i);
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(i[0]);
            exp_done.push_back('{i[0], 1'b0, '0});
        end
`else
        // 2: fixed priority with starvation guard at MAX_WAIT = 4
        for (int i = 0; i < 10; i++) begin
            bit p;
            p = (i == 4 || i == 9);
            exp_gnt.push_back(p);
            exp_done.push_back('{p, 1'b0, '0});
        end
`endif
        drive(0, 0, 1, 6'd10, 16'h1111);
        drive(1, 0, 1, 6'd11, 16'h2222);
`ifdef MEM_ARB_RR_EN
        burst(1, 1, 4);
`else
        burst(1, 1, 10);
`endif
        wait_idle();

        // Port 1 alone is granted every access slot
        for (int i = 0; i < 3; i++) begin
            exp_gnt.push_back(1'b1);
            exp_done.push_back('{1'b1, 1'b1, 16'h2222});
        end
        drive(1, 0, 0, 6'd11, '0);
        burst(0, 1, 3);
        wait_idle();

        // 4: cross-port read after write at the top address; rdata holds
        request(1, 1, 6'd63, 16'h0001, '0);
        request(0, 0, 6'd63, '0, 16'h0001);
        wait_idle();
        request(0, 1, 6'd30, 16'h7777, '0);
        request(1, 0, 6'd5, '0, 16'hBEEF);
        wait_idle();
        check("t4_rdata_hold", p0.rdata, 16'h0001);

        // 5: reset during ACCESS of a write suppresses it and its done
        request(0, 1, 6'd7, 16'h5555, '0);
        wait_idle();
        we0 = n_we;
        exp_gnt.push_back(1'b0);
        drive(0, 1, 1, 6'd7, 16'h1234);
        wait_gnt(0);
        @(posedge clk); #1;
        drive(0, 0, 1, 6'd7, 16'h1234);
        rst = 1'b1;
        @(negedge clk);
        check("t5_we_in_rst", mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_we_count", n_we - we0, 0);
        check("t5_busy", busy, 0);
        @(posedge clk); #1;
        request(0, 0, 6'd7, '0, 16'h5555);
        wait_idle();

        // 6: port 1 request withdrawn before grant leaves no trace
        we0 = n_we;
        request(0, 1, 6'd20, 16'h0F0F, '0);
        drive(1, 1, 1, 6'd21, 16'hDEAD);
        @(posedge clk); #1;
        drive(1, 0, 1, 6'd21, 16'hDEAD);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("t6_we_count", n_we - we0, 1);
        check("t6_we_addr", we_addr, 6'd20);
        request(0, 0, 6'd21, '0, 16'h0000);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
